// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Purpose  : Direct-mapped BTB with 2-bit saturating counters giving a
//            same-cycle fetch prediction, plus EX-stage resolution of
//            branches/jumps with a registered one-cycle redirect pulse.
// Options  : BPU_STATS_EN - when defined, enables the branch/mispredict
//            performance counters; otherwise the stat ports read 0.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch-side lookup
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    // execute-side resolve
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_srcA,
    input  logic [XLEN-1:0] ex_srcB,
    input  logic [XLEN-1:0] ex_pc_plus4,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    // redirect to fetch
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    // performance counters
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int        IDX         = $clog2(ENTRIES);
    localparam int        TAGW        = XLEN - IDX - 2;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [1:0] CTR_RESET  = 2'b01;
    localparam logic [1:0] CTR_ALLOC  = 2'b10;
    localparam logic [1:0] CTR_STRONG = 2'b11;

    // ------------------------------------------------------------------
    // BTB storage
    // ------------------------------------------------------------------
    logic            btb_valid  [ENTRIES];
    logic [TAGW-1:0] btb_tag    [ENTRIES];
    logic [XLEN-1:0] btb_target [ENTRIES];
    logic [1:0]      btb_ctr    [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch lookup (reads the pre-edge table, no write bypass)
    // ------------------------------------------------------------------
    logic [IDX-1:0]  f_idx;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;

    assign f_idx = fetch_pc[IDX+1:2];
    assign f_tag = fetch_pc[XLEN-1:IDX+2];
    assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    assign pred_taken  = f_hit && btb_ctr[f_idx][1];
    assign pred_target = pred_taken ? btb_target[f_idx] : (fetch_pc + XLEN'(4));

    // ------------------------------------------------------------------
    // Execute-stage resolution
    // ------------------------------------------------------------------
    logic [IDX-1:0]  e_idx;
    logic [TAGW-1:0] e_tag;
    logic            e_hit;
    logic            resolve;
    logic            cond;
    logic            actual_taken;
    logic [XLEN-1:0] taken_target;
    logic [XLEN-1:0] actual_target;
    logic            mispredict;
    logic            is_ctrl;

    assign e_idx = ex_pc[IDX+1:2];
    assign e_tag = ex_pc[XLEN-1:IDX+2];
    assign e_hit = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);

    // Instructions in EX while a redirect is outstanding are wrong-path.
    assign resolve = ex_valid && !redirect_valid;
    assign is_ctrl = ex_branch || ex_jump;

    // Branch condition decode; reserved funct3 codes are never taken.
    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = (ex_srcA == ex_srcB);
            3'b001:  cond = (ex_srcA != ex_srcB);
            3'b100:  cond = ($signed(ex_srcA) <  $signed(ex_srcB));
            3'b101:  cond = ($signed(ex_srcA) >= $signed(ex_srcB));
            3'b110:  cond = (ex_srcA <  ex_srcB);
            3'b111:  cond = (ex_srcA >= ex_srcB);
            default: cond = 1'b0;
        endcase
    end

    // Target and mispredict computation; JALR clears bit 0 of its sum.
    always_comb begin
        actual_taken = ex_jump || (ex_branch && cond);
        if (ex_jump && (ex_opcode == OPC_JALR)) begin
            taken_target = (ex_srcA + ex_imm) & ~XLEN'(1);
        end else begin
            taken_target = ex_pc + ex_imm;
        end
        actual_target = actual_taken ? taken_target : ex_pc_plus4;
        mispredict    = (actual_taken != ex_pred_taken) ||
                        (actual_taken && ex_pred_taken &&
                         (actual_target != ex_pred_target));
    end

    // Registered redirect pulse; a reset clears any pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= resolve && mispredict;
            if (resolve && mispredict) begin
                redirect_pc <= actual_target;
            end
        end
    end

    // BTB training on every resolved instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= CTR_RESET;
            end
        end else if (resolve) begin
            if (ex_jump) begin
                btb_valid[e_idx]  <= 1'b1;
                btb_tag[e_idx]    <= e_tag;
                btb_target[e_idx] <= actual_target;
                btb_ctr[e_idx]    <= CTR_STRONG;
            end else if (ex_branch) begin
                if (cond) begin
                    if (e_hit) begin
                        if (btb_ctr[e_idx] != CTR_STRONG) begin
                            btb_ctr[e_idx] <= btb_ctr[e_idx] + 2'd1;
                        end
                    end else begin
                        btb_valid[e_idx]  <= 1'b1;
                        btb_tag[e_idx]    <= e_tag;
                        btb_target[e_idx] <= actual_target;
                        btb_ctr[e_idx]    <= CTR_ALLOC;
                    end
                end else if (e_hit && (btb_ctr[e_idx] != 2'b00)) begin
                    btb_ctr[e_idx] <= btb_ctr[e_idx] - 2'd1;
                end
            end else if (ex_pred_taken) begin
                // A non-control instruction predicted taken is an alias:
                // drop the entry so the index stops steering fetch.
                btb_valid[e_idx] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BPU_STATS_EN
    // Count resolved control instructions and issued redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve && is_ctrl) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (resolve && mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

    // PC byte-offset bits never index the table.
    logic unused_bits;
    assign unused_bits = ^{fetch_pc[1:0], ex_pc[1:0], is_ctrl};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Purpose  : Directed self-checking bench for branch_predict_unit. Two DUTs
//            share the stimulus: the default 16-entry build and a 4-entry
//            build used for the index-alias scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_srcA, ex_srcB, ex_pc_plus4, ex_pred_target;
    logic        ex_branch, ex_jump, ex_pred_taken;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;

    logic        pred_taken, redirect_valid;
    logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispredicts;
    logic        p4_pred_taken, p4_redirect_valid;
    logic [31:0] p4_pred_target, p4_redirect_pc, p4_stat_branches, p4_stat_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.XLEN(32), .ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_pc_plus4(ex_pc_plus4),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_predict_unit #(.XLEN(32), .ENTRIES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(p4_pred_taken), .pred_target(p4_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_pc_plus4(ex_pc_plus4),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .redirect_valid(p4_redirect_valid), .redirect_pc(p4_redirect_pc),
        .stat_branches(p4_stat_branches), .stat_mispredicts(p4_stat_mispredicts)
    );

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ex_valid = 1'b0;
        rst_n    = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // Present one instruction in EX for a single edge.
    task automatic ex_op(input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic br, input logic jp,
                         input logic [6:0] op, input logic pt,
                         input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_pc_plus4    = pc + 32'd4;
        ex_imm         = imm;
        ex_srcA        = a;
        ex_srcB        = b;
        ex_funct3      = f3;
        ex_branch      = br;
        ex_jump        = jp;
        ex_opcode      = op;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        cycle();
        ex_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        fetch_pc = 32'h100;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %0b want 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        n_checks++; if (stat_branches !== 32'h0) begin n_fail++; $display("FAIL reset_stat_br: got %0d want 0", stat_branches); end
        // Mispredict registers a redirect, then reset asserts asynchronously.
        ex_op(32'h100, 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'h0);
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL premature_redirect: got %0b want 1", redirect_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_redirect_valid: got %0b want 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL async_rst_redirect_pc: got %h want 0", redirect_pc); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_rst_btb_cleared: got %0b want 0", pred_taken); end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_beq_alloc();
        ex_op(32'h100, 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'h104);
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_redirect_valid: got %0b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h140) begin n_fail++; $display("FAIL beq_redirect_pc: got %h want 00000140", redirect_pc); end
        cycle();
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_redirect_pulse: got %0b want 0", redirect_valid); end
        fetch_pc = 32'h100;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL beq_alloc_pred: got %0b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h140) begin n_fail++; $display("FAIL beq_alloc_target: got %h want 00000140", pred_target); end
    endtask

    // Counter walk from 10: T,T -> 11,11; N,N,N -> 10,01,00; then T -> 01.
    task automatic test_counter();
        fetch_pc = 32'h100;
        for (int i = 0; i < 2; i++) begin
            ex_op(32'h100, 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, OP_BR, 1'b1, 32'h140);
            n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ctr_taken%0d_no_redirect: got %0b want 0", i, redirect_valid); end
            n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_taken%0d_pred: got %0b want 1", i, pred_taken); end
        end
        // first not-taken: predicted taken, so it redirects to the fall-through
        ex_op(32'h100, 32'h40, 32'd5, 32'd6, 3'b000, 1'b1, 1'b0, OP_BR, 1'b1, 32'h140);
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL ctr_nt1_redirect: got %0b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL ctr_nt1_redirect_pc: got %h want 00000104", redirect_pc); end
        cycle();
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_nt1_pred (ctr 10): got %0b want 1", pred_taken); end
        ex_op(32'h100, 32'h40, 32'd5, 32'd6, 3'b000, 1'b1, 1'b0, OP_BR, 1'b1, 32'h140);
        n_checks++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL ctr_nt2_redirect_pc: got %h want 00000104", redirect_pc); end
        cycle();
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_nt2_pred (ctr 01): got %0b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL ctr_nt2_target: got %h want 00000104", pred_target); end
        ex_op(32'h100, 32'h40, 32'd5, 32'd6, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'h104);
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ctr_nt3_no_redirect: got %0b want 0", redirect_valid); end
        // ctr should now be 00: one taken lands at 01, still not-taken
        ex_op(32'h100, 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'h104);
        n_checks++; if (redirect_pc !== 32'h140) begin n_fail++; $display("FAIL ctr_floor_redirect_pc: got %h want 00000140", redirect_pc); end
        cycle();
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_floor_pred (ctr 01): got %0b want 0", pred_taken); end
    endtask

    task automatic test_jumps();
        ex_op(32'h200, 32'd4, 32'h1001, 32'h0, 3'b000, 1'b0, 1'b1, OP_JALR, 1'b1, 32'h1000);
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL jalr_redirect: got %0b want 1", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h1004) begin n_fail++; $display("FAIL jalr_redirect_pc: got %h want 00001004", redirect_pc); end
        cycle();
        fetch_pc = 32'h200;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL jalr_entry_pred: got %0b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h1004) begin n_fail++; $display("FAIL jalr_entry_target: got %h want 00001004", pred_target); end
        ex_op(32'h300, 32'h20, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, OP_JAL, 1'b0, 32'h304);
        n_checks++; if (redirect_pc !== 32'h320) begin n_fail++; $display("FAIL jal_redirect_pc: got %h want 00000320", redirect_pc); end
        cycle();
        ex_op(32'h300, 32'h20, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, OP_JAL, 1'b1, 32'h320);
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jal_correct_no_redirect: got %0b want 1'b0", redirect_valid); end
    endtask

    task automatic test_conditions();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [2:0]  vf [10];
        logic        vt [10];
        va = '{32'd5, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd1};
        vb = '{32'd5, 32'd5, 32'd6, 32'd1,        32'd1,        32'd1,        32'd1,        32'd5, 32'd5, 32'd1};
        vf = '{3'b000, 3'b001, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011, 3'b101};
        vt = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            ex_op(32'h40C, 32'h10, va[i], vb[i], vf[i], 1'b1, 1'b0, OP_BR, 1'b0, 32'h410);
            n_checks++; if (redirect_valid !== vt[i]) begin n_fail++; $display("FAIL cond%0d_f3_%b: redirect got %0b want %0b", i, vf[i], redirect_valid, vt[i]); end
            if (vt[i]) begin
                n_checks++; if (redirect_pc !== 32'h41C) begin n_fail++; $display("FAIL cond%0d_target: got %h want 0000041c", i, redirect_pc); end
            end
            cycle();
        end
        // target sum wraps modulo 2^32
        ex_op(32'hFFFFFFF0, 32'h20, 32'd7, 32'd7, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'hFFFFFFF4);
        n_checks++; if (redirect_pc !== 32'h10) begin n_fail++; $display("FAIL wrap_target: got %h want 00000010", redirect_pc); end
        cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_op(32'h100, 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'h104);
        n_checks++; if (redirect_pc !== 32'h140) begin n_fail++; $display("FAIL b2b_first_pc: got %h want 00000140", redirect_pc); end
        // second branch arrives while the redirect is high: must be ignored
        ex_op(32'h508, 32'h80, 32'd9, 32'd9, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'h50C);
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second_redirect: got %0b want 0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h140) begin n_fail++; $display("FAIL b2b_redirect_pc_held: got %h want 00000140", redirect_pc); end
        fetch_pc = 32'h508;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL b2b_no_alloc: got %0b want 0", pred_taken); end
`ifdef BPU_STATS_EN
        n_checks++; if (stat_branches !== 32'd1) begin n_fail++; $display("FAIL b2b_stat_branches: got %0d want 1", stat_branches); end
        n_checks++; if (stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL b2b_stat_mispredicts: got %0d want 1", stat_mispredicts); end
`else
        n_checks++; if (stat_branches !== 32'd0) begin n_fail++; $display("FAIL b2b_stat_branches_tied: got %0d want 0", stat_branches); end
        n_checks++; if (stat_mispredicts !== 32'd0) begin n_fail++; $display("FAIL b2b_stat_mispredicts_tied: got %0d want 0", stat_mispredicts); end
`endif
        // unknown operands with ex_valid low must leave everything unchanged
        ex_pc = 'x; ex_imm = 'x; ex_srcA = 'x; ex_srcB = 'x; ex_branch = 'x;
        ex_jump = 'x; ex_pred_taken = 'x; ex_funct3 = 'x; ex_pc_plus4 = 'x;
        cycle();
        cycle();
        fetch_pc = 32'h100;
        #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL idle_x_redirect: got %0b want 0", redirect_valid); end
        n_checks++; if (pred_target !== 32'h140) begin n_fail++; $display("FAIL idle_x_btb_held: got %h want 00000140", pred_target); end
    endtask

    task automatic test_alias();
        do_reset();
        ex_op(32'h100, 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b0, OP_BR, 1'b0, 32'h104);
        cycle();
        fetch_pc = 32'h100;
        #1;
        n_checks++; if (p4_pred_target !== 32'h140) begin n_fail++; $display("FAIL alias_alloc_target: got %h want 00000140", p4_pred_target); end
        fetch_pc = 32'h110;
        #1;
        n_checks++; if (p4_pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_tag_miss: got %0b want 0", p4_pred_taken); end
        n_checks++; if (p4_pred_target !== 32'h114) begin n_fail++; $display("FAIL alias_tag_miss_target: got %h want 00000114", p4_pred_target); end
        ex_op(32'h110, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, OP_ALU, 1'b1, 32'h140);
        n_checks++; if (p4_redirect_valid !== 1'b1) begin n_fail++; $display("FAIL alias_redirect: got %0b want 1", p4_redirect_valid); end
        n_checks++; if (p4_redirect_pc !== 32'h114) begin n_fail++; $display("FAIL alias_redirect_pc: got %h want 00000114", p4_redirect_pc); end
        cycle();
        fetch_pc = 32'h100;
        #1;
        n_checks++; if (p4_pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_invalidated: got %0b want 0", p4_pred_taken); end
        n_checks++; if (p4_pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_invalidated_target: got %h want 00000104", p4_pred_target); end
    endtask

    initial begin
        rst_n = 1'b0; fetch_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_imm = '0;
        ex_srcA = '0; ex_srcB = '0; ex_pc_plus4 = '0; ex_branch = 1'b0;
        ex_jump = 1'b0; ex_opcode = '0; ex_funct3 = '0; ex_pred_taken = 1'b0;
        ex_pred_target = '0;
        test_reset();
        test_beq_alloc();
        test_counter();
        test_jumps();
        test_conditions();
        test_back_to_back();
        test_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
